// File: rtl/morse_key_decoder.sv
// morse_key_decoder: decodes a hand-keyed Morse push-button into one letter.
// The raw key is synchronized, debounced, and then timed in 5 Hz units. Each
// press becomes a dot or a dash, and a long release closes the letter. The
// output encoding can be replayed through the Morse buzzer driver unchanged.
//
// Ports:
//   clk          in   system clock (1 MHz)
//   rst          in   synchronous, active-high reset
//   clk_5hz      in   5 Hz unit clock (level); rising edge gives a one-cycle tick
//   key_in       in   raw asynchronous key, 1 = pressed
//   key_active   out  debounced key state
//   morse_code   out  last decoded letter, first symbol at bit 4, 1 = dash
//   morse_len    out  symbol count of last letter, 1..5
//   letter_valid out  one-cycle pulse when morse_code/morse_len update
//   letter_err   out  one-cycle pulse when a letter of more than 5 symbols is dropped
module morse_key_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES  = 20000,
  parameter int unsigned DASH_UNITS       = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_5hz,
  input  logic       key_in,
  output logic       key_active,
  output logic [4:0] morse_code,
  output logic [2:0] morse_len,
  output logic       letter_valid,
  output logic       letter_err
);

  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned GAP_W    = CNT_W + 1;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned MAX_SYMS = 5;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(DASH_UNITS);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(LETTER_GAP_UNITS);
  localparam logic [LEN_W-1:0] SYM_MAX  = LEN_W'(MAX_SYMS);
  localparam logic [LEN_W-1:0] TOP_BIT  = LEN_W'(MAX_SYMS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    EMIT    = 2'd3
  } state_e;

  // Input conditioning registers
  logic            sync1_q, sync2_q;
  logic            key_db_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            clk_5hz_prev_q;
  logic            tick;

  // FSM and letter assembly registers
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    press_q, press_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]    sym_q, sym_d;
  logic                ovf_q, ovf_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  assign tick = clk_5hz & ~clk_5hz_prev_q;

  // Synchronizer, debounce and unit-clock edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      key_db_q       <= 1'b0;
      db_cnt_q       <= '0;
      clk_5hz_prev_q <= 1'b0;
    end else begin
      sync1_q        <= key_in;
      sync2_q        <= sync1_q;
      clk_5hz_prev_q <= clk_5hz;
      if (sync2_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        key_db_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      press_q <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      sym_q   <= '0;
      ovf_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      sym_q   <= sym_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The letter outputs are loaded on the transition into
  // EMIT so the registered pulse is visible during the EMIT cycle itself,
  // one clock after the tick that closes the gap.
  always_comb begin
    state_d = state_q;
    press_d = press_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    len_d   = len_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_db_q) begin
          state_d = PRESS;
          press_d = '0;
          shift_d = '0;
          sym_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      PRESS: begin
        if (!key_db_q) begin
          // Fall wins over a coincident tick: the tick is not counted.
          state_d = RELEASE;
          gap_d   = '0;
          if (sym_q < SYM_MAX) begin
            shift_d[TOP_BIT - sym_q] = (press_q >= DASH_MIN);
            sym_d                    = sym_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (tick && (press_q != CNT_MAX)) begin
          press_d = press_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (key_db_q) begin
          state_d = PRESS;
          press_d = '0;
        end else if (tick) begin
          if ((GAP_W'(gap_q) + GAP_W'(1)) == GAP_END) begin
            state_d = EMIT;
            if (!ovf_q) begin
              code_d  = shift_q;
              len_d   = sym_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (gap_q != CNT_MAX) begin
            gap_d = gap_q + CNT_W'(1);
          end
        end
      end

      EMIT: begin
        // A key press arriving now is still level-held and is taken in IDLE.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign key_active   = key_db_q;
  assign morse_code   = code_q;
  assign morse_len    = len_q;
  assign letter_valid = valid_q;
  assign letter_err   = err_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: scoreboard bench for morse_key_decoder. Letters are
// described as lists of press lengths (in 5 Hz units); the expected decode is
// pushed when a letter starts and a monitor pops it on every output pulse.
module tb_morse_key_decoder;

  localparam int unsigned DEB  = 4;
  localparam int unsigned DASH = 2;
  localparam int unsigned GAP  = 3;
  localparam int          UNIT = 100;

  typedef struct packed {
    logic       err;
    logic [4:0] code;
    logic [2:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_5hz = 1'b0;
  logic       key_in = 1'b0;
  logic       key_active;
  logic [4:0] morse_code;
  logic [2:0] morse_len;
  logic       letter_valid;
  logic       letter_err;

  morse_key_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .DASH_UNITS      (DASH),
    .LETTER_GAP_UNITS(GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_5hz     (clk_5hz),
    .key_in      (key_in),
    .key_active  (key_active),
    .morse_code  (morse_code),
    .morse_len   (morse_len),
    .letter_valid(letter_valid),
    .letter_err  (letter_err)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         letter_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_tick_cyc = -1;
  logic       tb_5hz_prev = 1'b0;
  int         phase = 0;
  logic [4:0] held_code = '0;
  logic [2:0] held_len = '0;
  int         ka_rises = 0;
  int         ka_rise_cyc = -1;
  logic       ka_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycle counter and the bench's own view of unit ticks
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (clk_5hz && !tb_5hz_prev) last_tick_cyc = cyc;
    tb_5hz_prev = clk_5hz;
  end

  // Monitor: every output pulse consumes one expected letter
  always @(negedge clk) begin
    if (!rst && key_active && !ka_prev) begin
      ka_rises++;
      ka_rise_cyc = cyc;
    end
    ka_prev = key_active;
    if (letter_valid || letter_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, letter_valid, letter_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_exclusive", 32'(letter_valid & letter_err), 32'd0);
        check("pulse_kind", 32'(letter_err), 32'(mon_e.err));
        check("morse_code", 32'(morse_code), 32'(mon_e.code));
        check("morse_len", 32'(morse_len), 32'(mon_e.len));
        check("pulse_latency", 32'(cyc), 32'(last_tick_cyc));
      end
    end
  end

  // Advance n clocks; clk_5hz is high for the first half of each unit
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_5hz = (phase < UNIT / 2);
      phase   = (phase + 1) % UNIT;
    end
  endtask

  task automatic align();
    while (phase != 20) cycles(1);
  endtask

  // One press of n units (0 = shorter than a unit) followed by a g-unit release
  task automatic press_release(input int n, input int g);
    if (n == 0) begin
      key_in = 1'b1;
      cycles(40);
      key_in = 1'b0;
      cycles(60 + UNIT * (g - 1));
    end else begin
      key_in = 1'b1;
      cycles(UNIT * n);
      key_in = 1'b0;
      cycles(UNIT * g);
    end
  endtask

  // Expected decode of letter_q: dash when press >= DASH units
  task automatic push_expect();
    exp_t       e;
    logic [4:0] c;
    int         n;
    n = letter_q.size();
    c = '0;
    for (int i = 0; i < n && i < 5; i++)
      if (letter_q[i] >= int'(DASH)) c = c | (5'b10000 >> i);
    if (n > 5) begin
      e.err  = 1'b1;
      e.code = held_code;
      e.len  = held_len;
    end else begin
      e.err     = 1'b0;
      e.code    = c;
      e.len     = 3'(n);
      held_code = c;
      held_len  = 3'(n);
    end
    exp_q.push_back(e);
  endtask

  // intra = 0 picks a random 1..2 unit gap between symbols
  task automatic send_letter(input int intra, input int end_gap);
    int n;
    push_expect();
    n = letter_q.size();
    for (int i = 0; i < n; i++)
      press_release(letter_q[i],
                    (i == n - 1) ? end_gap : ((intra == 0) ? int'($urandom_range(1, 2)) : intra));
  endtask

  initial begin
    int rises0;
    int settle_cyc;

    rst = 1'b1;
    cycles(3);
    check("rst_key_active", 32'(key_active), 32'd0);
    check("rst_code", 32'(morse_code), 32'd0);
    check("rst_len", 32'(morse_len), 32'd0);
    check("rst_valid", 32'(letter_valid), 32'd0);
    check("rst_err", 32'(letter_err), 32'd0);
    rst = 1'b0;
    align();

    // E: single one-unit dot
    letter_q = '{1};
    send_letter(1, 3);

    // K: dash dot dash
    letter_q = '{3, 1, 3};
    send_letter(1, 3);

    // Six dots overflow: error pulse, outputs keep K
    letter_q = '{1, 1, 1, 1, 1, 1};
    send_letter(1, 3);

    // Bouncing key settles high, one dot results
    letter_q = '{1};
    push_expect();
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0);
      cycles(2);
    end
    key_in     = 1'b1;
    settle_cyc = cyc;
    rises0     = ka_rises;
    cycles(80);
    check("bounce_rises", 32'(ka_rises - rises0), 32'd1);
    check("bounce_delay", 32'(ka_rise_cyc), 32'(settle_cyc + 6));
    key_in = 1'b0;
    cycles(UNIT * 3);

    // Dash threshold and a 2-unit gap that continues the letter
    letter_q = '{1, 2};
    send_letter(2, 3);

    // Reset during the second press of A
    key_in = 1'b1;
    cycles(UNIT);
    key_in = 1'b0;
    cycles(UNIT);
    key_in = 1'b1;
    cycles(50);
    rst    = 1'b1;
    key_in = 1'b0;
    cycles(1);
    check("midrst_key_active", 32'(key_active), 32'd0);
    check("midrst_code", 32'(morse_code), 32'd0);
    check("midrst_len", 32'(morse_len), 32'd0);
    check("midrst_pulses", 32'({letter_valid, letter_err}), 32'd0);
    cycles(3);
    rst       = 1'b0;
    held_code = '0;
    held_len  = '0;
    align();

    // T after reset
    letter_q = '{3};
    send_letter(1, 3);

    // Very long press saturates the counter and is still a dash
    letter_q = '{17};
    send_letter(1, 3);

    // Random letters of 1..6 symbols
    for (int l = 0; l < 16; l++) begin
      int n;
      n = int'($urandom_range(1, 6));
      letter_q.delete();
      for (int i = 0; i < n; i++) letter_q.push_back(int'($urandom_range(0, 3)));
      send_letter(0, int'($urandom_range(3, 4)));
    end

    cycles(2 * UNIT);
    check("pending_letters", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive-side counterpart to the Morse buzzer driver: decodes a hand-keyed Morse push-button into one letter at a time.
- Input path: 2-flop synchronizer, then debounce, then press/release durations measured in 5 Hz units.
- Each press is classified as dot or dash. A long release closes the letter.
- Output encoding matches the driver's input: morse_code[4:0] with the first symbol at bit 4 and 1 = dash, plus morse_len[2:0]. A decoded letter can therefore be replayed through the driver unchanged.

Parameters:
- DEBOUNCE_CYCLES, 20000, clk cycles key_sync must be stable before key_db follows it (20 ms at 1 MHz).
- DASH_UNITS, 2, press tick count at or above which a press is a dash; below it is a dot.
- LETTER_GAP_UNITS, 3, release ticks that end a letter.

Ports:
- clk  in  1  system clock (1 MHz).
- rst  in  1  synchronous, active-high reset.
- clk_5hz  in  1  5 Hz unit clock (level); rising edge detected internally, giving a one-cycle tick.
- key_in  in  1  raw asynchronous key, 1 = pressed.
- key_active  out  1  debounced key state (key_db).
- morse_code  out  5  last decoded letter; symbol k at bit 4-k, unused bits 0.
- morse_len  out  3  symbol count of last letter, 1..5.
- letter_valid  out  1  one-cycle pulse when morse_code/morse_len update.
- letter_err  out  1  one-cycle pulse when a letter of more than 5 symbols is discarded.

Behaviour:
- Reset (rst high at a clk edge): all outputs 0; state IDLE; sync/debounce flops 0; counters 0; clk_5hz_prev 0. A reset mid-letter discards the partial letter with no pulse.
- Synchronizer: key_sync = key_in delayed 2 flops.
- Debounce:
  - Counter clears whenever key_sync == key_db.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, key_db <= key_sync and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- tick = clk_5hz & ~clk_5hz_prev.
- Internal registers:
  - shift_code[4:0], sym_cnt[2:0], overflow.
  - press_cnt[3:0] and gap_cnt[3:0], both saturating at 15.
- FSM states:
  - IDLE: no symbols pending. On key_db rise → PRESS; press_cnt=0, shift_code=0, sym_cnt=0, overflow=0.
  - PRESS: each tick increments press_cnt (saturating). On key_db fall → RELEASE; gap_cnt=0; classify with sym = (press_cnt >= DASH_UNITS).
    - If sym_cnt < 5: shift_code[4-sym_cnt] <= sym and sym_cnt++.
    - Else: overflow <= 1 and the symbol is dropped.
    - A tick in the same cycle as the fall is not counted.
    - A press shorter than one tick (press_cnt=0) is a dot.
  - RELEASE:
    - On key_db rise → PRESS; press_cnt=0. The letter continues.
    - Else each tick increments gap_cnt. When gap_cnt+1 == LETTER_GAP_UNITS → EMIT.
    - A rise and a tick in the same cycle: the rise wins and the tick is ignored.
  - EMIT (one cycle), then → IDLE:
    - If !overflow: morse_code <= shift_code; morse_len <= sym_cnt; letter_valid=1.
    - If overflow: letter_err=1 and outputs hold their previous values.
    - A key_db rise during EMIT is seen in IDLE on the next cycle. No press is lost, because key_db is level-held.
- letter_valid and letter_err are registered and never both high.
- Latency: pulse asserted 1 clk after the tick that completes the gap.
- morse_code/morse_len hold until the next valid letter.
- key_active = key_db.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4; clk_5hz period 100 clk (tick every 100 cycles).
1. Single dot: press spanning 1 tick, then release ≥3 ticks → one letter_valid, morse_code=5'b00000, morse_len=1 ("E"). letter_valid rises exactly 1 clk after the 3rd release tick.
2. "K" (dash-dot-dash): presses of 3, 1, 3 ticks with 1-tick releases, then a 3-tick release → morse_code=5'b10100, morse_len=3, a single letter_valid. No pulse during the 1-tick gaps.
3. Six dots with 1-tick gaps, then a 3-tick release → letter_err pulse, no letter_valid, and morse_code/morse_len keep the prior letter.
4. Bounce: key_in toggles every 2 clk for 20 clk, then settles high → key_active rises once, 2+4 clk after settling. Only one symbol is recorded.
5. Boundary: press count exactly DASH_UNITS-1=1 gives a dot and exactly 2 gives a dash. Release of exactly 2 ticks followed by a press continues the same letter, giving morse_len=2 after the final gap.
6. Reset mid-letter: assert rst during the second press of "A" → all outputs 0 the next cycle and no pulse. A subsequent "T" (one 3-tick press) decodes to 5'b10000, len=1.
